// File: rtl/rle_pkg.sv
// rle_pkg: shared widths, result entry layout and packing helper for the RLE engine
package rle_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W = 8;
    localparam int VAL_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [VAL_W-1:0] value;
    } rle_entry_t;
    function automatic logic [DEF_DATA_W-1:0] pack_entry(input rle_entry_t e);
        return DEF_DATA_W'(e);
    endfunction
endpackage

// File: rtl/rle_if.sv
// rle_if: raw write port and result read port of the RLE engine
interface rle_if import rle_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              write_enable_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] write_data_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] read_data_b;
    modport master (output write_enable_a, addr_a, write_data_a, addr_b, input read_data_b);
    modport slave (input write_enable_a, addr_a, write_data_a, addr_b, output read_data_b);
endinterface

// File: rtl/rle_sdp_ram.sv
// rle_sdp_ram: simple dual-port RAM, one write port and one registered read-first read port
module rle_sdp_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // only the output register is reset; array contents survive reset
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else rdata <= mem[raddr];
endmodule

// File: rtl/rle_engine.sv
// rle_engine: streams raw write bursts into (count, value) run entries in a readable result RAM
module rle_engine import rle_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic  clk,
    input logic  rst,
    rle_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t            state, state_nxt;
    logic [VAL_W-1:0]  run_val, run_val_nxt, din;
    logic [CNT_W-1:0]  run_cnt, run_cnt_nxt;
    logic [ADDR_W-1:0] out_ptr, out_ptr_nxt, res_addr;
    logic              term_pending, term_nxt, res_we;
    rle_entry_t        res_entry;
    logic [DATA_W-1:0] raw_unused;
    assign din = bus.write_data_a[VAL_W-1:0];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            run_val      <= '0;
            run_cnt      <= '0;
            out_ptr      <= '0;
            term_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            run_val      <= run_val_nxt;
            run_cnt      <= run_cnt_nxt;
            out_ptr      <= out_ptr_nxt;
            term_pending <= term_nxt;
        end
    // terminator is the default write; it can only coincide with IDLE, which never writes
    always_comb begin
        state_nxt   = state;
        run_val_nxt = run_val;
        run_cnt_nxt = run_cnt;
        out_ptr_nxt = out_ptr;
        term_nxt    = 1'b0;
        res_we      = term_pending;
        res_addr    = out_ptr + 1'b1;
        res_entry   = '0;
        if (state == IDLE) begin
            if (bus.write_enable_a) begin
                state_nxt   = ACTIVE;
                out_ptr_nxt = '0;
                run_val_nxt = din;
                run_cnt_nxt = CNT_W'(1);
            end
        end else if (bus.write_enable_a && din == run_val && run_cnt < CNT_MAX) begin
            run_cnt_nxt = run_cnt + 1'b1;
        end else begin
            res_we    = 1'b1;
            res_addr  = out_ptr;
            res_entry = '{count: run_cnt, value: run_val};
            if (bus.write_enable_a) begin
                out_ptr_nxt = out_ptr + 1'b1;
                run_val_nxt = din;
                run_cnt_nxt = CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                term_nxt  = 1'b1;
            end
        end
    end
    rle_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_raw (
        .clk  (clk),
        .rst  (rst),
        .we   (bus.write_enable_a),
        .waddr(bus.addr_a),
        .wdata(bus.write_data_a),
        .raddr('0),
        .rdata(raw_unused)
    );
    rle_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_res (
        .clk  (clk),
        .rst  (rst),
        .we   (res_we),
        .waddr(res_addr),
        .wdata(DATA_W'(pack_entry(res_entry))),
        .raddr(bus.addr_b),
        .rdata(bus.read_data_b)
    );
endmodule

// File: tb/tb_rle_engine.sv
// tb_rle_engine: scoreboard bench, a reference encoder queues expected entries per burst, readback pops them
module tb_rle_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] q[$];
    rle_if bus();
    rle_engine dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic burst(input logic [31:0] d[$], input int gap);
        logic [7:0] v, c;
        v = '0;
        c = '0;
        for (int i = 0; i < d.size(); i++) begin
            if (i == 0) begin
                v = d[i][7:0];
                c = 8'd1;
            end else if (d[i][7:0] == v && c != 8'hFF) begin
                c++;
            end else begin
                exp_q.push_back({16'h0, c, v});
                v = d[i][7:0];
                c = 8'd1;
            end
            @(negedge clk);
            bus.write_enable_a = 1'b1;
            bus.addr_a = 10'(i + 1);
            bus.write_data_a = d[i];
        end
        exp_q.push_back({16'h0, c, v});
        exp_q.push_back('0);
        @(negedge clk);
        bus.write_enable_a = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask
    task automatic readback(input string tag);
        int a;
        a = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            bus.addr_b = 10'(a);
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, a), bus.read_data_b, exp_q.pop_front());
            a++;
        end
    endtask
    initial begin
        bus.write_enable_a = 1'b0;
        bus.addr_a = '0;
        bus.write_data_a = '0;
        bus.addr_b = '0;
        repeat (2) @(negedge clk);
        check("reset", bus.read_data_b, 32'h0);
        rst = 1'b0;
        q = {32'd5, 32'd5, 32'd5, 32'd7, 32'd7, 32'd9};
        burst(q, 5);
        readback("basic");
        q = {32'o7, 32'o7, 32'o10, 32'o10, 32'o12};
        burst(q, 3);
        readback("octal");
        q = {32'hA, 32'hA, 32'hF, 32'hF, 32'hF, 32'h1};
        burst(q, 3);
        readback("hex");
        q = {32'd1, 32'd2};
        burst(q, 1);
        exp_q.delete();
        q = {32'd4};
        burst(q, 3);
        exp_q.push_back('0);
        readback("b2b");
        q = {32'h1FF, 32'h0FF};
        burst(q, 3);
        readback("mask");
        q.delete();
        for (int i = 0; i < 300; i++) q.push_back(32'h42);
        burst(q, 3);
        readback("sat");
        @(negedge clk);
        bus.addr_b = '0;
        @(negedge clk);
        check("pre_rst", bus.read_data_b, 32'h0000FF42);
        bus.write_enable_a = 1'b1;
        bus.write_data_a = 32'd9;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.write_enable_a = 1'b0;
        #1;
        check("rst_async", bus.read_data_b, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        q = {32'd3, 32'd3};
        burst(q, 3);
        readback("post_rst");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
